stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 23 ++
 rtl/stream_fifo.sv | 118 +++++++++++
 tb/tb_stream_fifo.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared read-mode enumeration and sizing helper for the stream FIFO family.
// The count width covers occupancy 0..DEPTH inclusive.
package fifo_pkg;

   typedef enum logic {
      FIFO_MODE_STD  = 1'b0,
      FIFO_MODE_FWFT = 1'b1
   } fifo_mode_e;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one combinational read port.
// No reset on the array; contents are only meaningful between the FIFO pointers.
module fifo_mem #(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATAWIDTH-1:0]     wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATAWIDTH-1:0]     rd_data
);

   logic [DATAWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Single-clock FIFO with registered occupancy flags and registered or fall-through read data.
// Define STREAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module stream_fifo
   import fifo_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 0,
   parameter int AF_LEVEL  = DEPTH - 2,
   parameter int AE_LEVEL  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          write_en,
   input  logic [DATAWIDTH-1:0]          data_in,
   input  logic                          read_en,
   output logic [DATAWIDTH-1:0]          data_out,
   output logic                          read_valid,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
`ifdef STREAM_FIFO_ERR_FLAGS_EN
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
`else
   output logic [count_width(DEPTH)-1:0] count
`endif
);

   localparam int         AW   = $clog2(DEPTH);
   localparam int         CW   = count_width(DEPTH);
   localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count_nxt;
   logic                 rd_acc;
   logic                 wr_acc;
   logic [DATAWIDTH-1:0] head;

   // A full FIFO still takes a write when the same cycle frees a slot.
   assign rd_acc = read_en & ~empty;
   assign wr_acc = write_en & (~full | rd_acc);

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
      else if (rd_acc && !wr_acc) count_nxt = count - CW'(1);
   end

   // DEPTH is a power of two, so pointer increments wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         count        <= count_nxt;
         full         <= (count_nxt == FULL_LVL);
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_LVL);
         almost_empty <= (count_nxt <= AE_LVL);
      end
   end

   fifo_mem #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   if (MODE == FIFO_MODE_FWFT) begin : g_fwft
      // Gate to zero while empty so stale array contents never leak out.
      assign data_out   = empty ? '0 : head;
      assign read_valid = ~empty;
   end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_out   <= '0;
            read_valid <= 1'b0;
         end else begin
            read_valid <= rd_acc;
            if (rd_acc) data_out <= head;
         end
      end
   end

`ifdef STREAM_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (write_en && full && !rd_acc) overflow  <= 1'b1;
         if (read_en && empty)            underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: three instances (DEPTH=4 std, DEPTH=4 FWFT, DEPTH=8 std) sharing one clock and reset.
// The DEPTH=8 instance is driven randomly against a queue model of FIFO semantics.
module tb_stream_fifo;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic       w4_en, r4_en, rv4, full4, empty4, af4, ae4;
   logic [7:0] d4_in, d4_out;
   logic [2:0] cnt4;
   logic       wf_en, rf_en, rvf, fullf, emptyf, aff, aef;
   logic [7:0] df_in, df_out;
   logic [2:0] cntf;
   logic       w8_en, r8_en, rv8, full8, empty8, af8, ae8;
   logic [7:0] d8_in, d8_out;
   logic [3:0] cnt8;
`ifdef STREAM_FIFO_ERR_FLAGS_EN
   logic ov4, un4, ovf, unf, ov8, un8;
`endif

   stream_fifo #(.DATAWIDTH(8), .DEPTH(4), .FWFT(0)) u4 (
      .clk(clk), .rst(rst), .write_en(w4_en), .data_in(d4_in), .read_en(r4_en),
      .data_out(d4_out), .read_valid(rv4), .full(full4), .empty(empty4),
      .almost_full(af4), .almost_empty(ae4),
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      .overflow(ov4), .underflow(un4),
`endif
      .count(cnt4));

   stream_fifo #(.DATAWIDTH(8), .DEPTH(4), .FWFT(1)) uf (
      .clk(clk), .rst(rst), .write_en(wf_en), .data_in(df_in), .read_en(rf_en),
      .data_out(df_out), .read_valid(rvf), .full(fullf), .empty(emptyf),
      .almost_full(aff), .almost_empty(aef),
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      .overflow(ovf), .underflow(unf),
`endif
      .count(cntf));

   stream_fifo #(.DATAWIDTH(8), .DEPTH(8), .FWFT(0)) u8 (
      .clk(clk), .rst(rst), .write_en(w8_en), .data_in(d8_in), .read_en(r8_en),
      .data_out(d8_out), .read_valid(rv8), .full(full8), .empty(empty8),
      .almost_full(af8), .almost_empty(ae8),
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      .overflow(ov8), .underflow(un8),
`endif
      .count(cnt8));

   // Each cycle task applies inputs, lets one rising edge pass, samples 1 time unit later.
   task automatic cyc4(input logic we, input logic [7:0] d, input logic re);
      w4_en = we; d4_in = d; r4_en = re;
      @(posedge clk); #1;
      w4_en = 1'b0; r4_en = 1'b0;
   endtask

   task automatic cycf(input logic we, input logic [7:0] d, input logic re);
      wf_en = we; df_in = d; rf_en = re;
      @(posedge clk); #1;
      wf_en = 1'b0; rf_en = 1'b0;
   endtask

   task automatic cyc8(input logic we, input logic [7:0] d, input logic re);
      w8_en = we; d8_in = d; r8_en = re;
      @(posedge clk); #1;
      w8_en = 1'b0; r8_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      w4_en = 0; r4_en = 0; d4_in = 0;
      wf_en = 0; rf_en = 0; df_in = 0;
      w8_en = 0; r8_en = 0; d8_in = 0;
      #2;
      checks++;
      if ({full4, empty4, af4, ae4, cnt4, rv4, d4_out} !== {4'b0101, 3'd0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_u4 got=%b exp=%b", {full4, empty4, af4, ae4, cnt4, rv4, d4_out},
                  {4'b0101, 3'd0, 1'b0, 8'h00});
      end
      checks++;
      if ({fullf, emptyf, aff, aef, cntf, rvf, df_out} !== {4'b0101, 3'd0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_fwft got=%b exp=%b", {fullf, emptyf, aff, aef, cntf, rvf, df_out},
                  {4'b0101, 3'd0, 1'b0, 8'h00});
      end
      checks++;
      if ({full8, empty8, af8, ae8, cnt8, rv8, d8_out} !== {4'b0101, 4'd0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_u8 got=%b exp=%b", {full8, empty8, af8, ae8, cnt8, rv8, d8_out},
                  {4'b0101, 4'd0, 1'b0, 8'h00});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [7:0] e;
      for (int i = 0; i < 4; i++) cyc4(1'b1, 8'(8'hA1 + i), 1'b0);
      checks++;
      if ({full4, empty4, af4, ae4, cnt4} !== {4'b1010, 3'd4}) begin
         failures++;
         $display("FAIL fill_flags got=%b exp=%b", {full4, empty4, af4, ae4, cnt4}, {4'b1010, 3'd4});
      end
      cyc4(1'b1, 8'hA5, 1'b0);
      checks++;
      if ({full4, cnt4} !== {1'b1, 3'd4}) begin
         failures++;
         $display("FAIL drop_on_full got=%b exp=%b", {full4, cnt4}, {1'b1, 3'd4});
      end
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      checks++;
      if (ov4 !== 1'b1) begin
         failures++;
         $display("FAIL overflow_set got=%b exp=1", ov4);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         e = 8'(8'hA1 + i);
         cyc4(1'b0, 8'h00, 1'b1);
         checks++;
         if ({rv4, d4_out} !== {1'b1, e}) begin
            failures++;
            $display("FAIL drain_word%0d got=%b/%h exp=1/%h", i, rv4, d4_out, e);
         end
      end
      cyc4(1'b0, 8'h00, 1'b0);
      checks++;
      if ({rv4, d4_out, empty4, cnt4} !== {1'b0, 8'hA4, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL drain_end got=%b/%h/%b/%0d exp=0/a4/1/0", rv4, d4_out, empty4, cnt4);
      end
      cyc4(1'b0, 8'h00, 1'b1);
      checks++;
      if ({rv4, d4_out, empty4} !== {1'b0, 8'hA4, 1'b1}) begin
         failures++;
         $display("FAIL read_empty got=%b/%h/%b exp=0/a4/1", rv4, d4_out, empty4);
      end
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      checks++;
      if (un4 !== 1'b1) begin
         failures++;
         $display("FAIL underflow_set got=%b exp=1", un4);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [$];
      logic [7:0] e;
      for (int i = 0; i < 4; i++) cyc4(1'b1, 8'(8'hC1 + i), 1'b0);
      cyc4(1'b1, 8'hB0, 1'b1);
      checks++;
      if ({full4, cnt4, rv4, d4_out} !== {1'b1, 3'd4, 1'b1, 8'hC1}) begin
         failures++;
         $display("FAIL full_rw got=%b/%0d/%b/%h exp=1/4/1/c1", full4, cnt4, rv4, d4_out);
      end
      exp_q = '{8'hC2, 8'hC3, 8'hC4, 8'hB0};
      for (int i = 0; i < 4; i++) begin
         e = exp_q[i];
         cyc4(1'b0, 8'h00, 1'b1);
         checks++;
         if ({rv4, d4_out} !== {1'b1, e}) begin
            failures++;
            $display("FAIL full_rw_drain%0d got=%b/%h exp=1/%h", i, rv4, d4_out, e);
         end
      end
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      checks++;
      if ({ov4, un4} !== 2'b11) begin
         failures++;
         $display("FAIL sticky_flags got=%b exp=11", {ov4, un4});
      end
`endif
   endtask

   task automatic test_fwft();
      cycf(1'b1, 8'h5C, 1'b0);
      checks++;
      if ({emptyf, rvf, df_out, cntf} !== {1'b0, 1'b1, 8'h5C, 3'd1}) begin
         failures++;
         $display("FAIL fwft_first got=%b/%b/%h/%0d exp=0/1/5c/1", emptyf, rvf, df_out, cntf);
      end
      cycf(1'b0, 8'h00, 1'b1);
      checks++;
      if ({emptyf, rvf, cntf} !== {1'b1, 1'b0, 3'd0}) begin
         failures++;
         $display("FAIL fwft_pop got=%b/%b/%0d exp=1/0/0", emptyf, rvf, cntf);
      end
      cycf(1'b1, 8'h11, 1'b0);
      cycf(1'b1, 8'h22, 1'b0);
      checks++;
      if (df_out !== 8'h11) begin
         failures++;
         $display("FAIL fwft_head got=%h exp=11", df_out);
      end
      cycf(1'b0, 8'h00, 1'b1);
      checks++;
      if ({df_out, cntf} !== {8'h22, 3'd1}) begin
         failures++;
         $display("FAIL fwft_next got=%h/%0d exp=22/1", df_out, cntf);
      end
      cycf(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_random();
      logic [7:0] q [$];
      logic [7:0] last = 8'h00;
      logic [7:0] d;
      logic       we, re, racc, wacc;
      int         pw [4] = '{80, 50, 20, 0};
      int         pr [4] = '{30, 50, 80, 100};
      int         len [4] = '{60, 60, 60, 12};
      int         full_seen = 0;
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < len[ph]; c++) begin
            we = ($urandom_range(0, 99) < pw[ph]);
            re = ($urandom_range(0, 99) < pr[ph]);
            d  = 8'($urandom);
            racc = re && (q.size() > 0);
            wacc = we && (q.size() < 8 || racc);
            cyc8(we, d, re);
            if (racc) last = q.pop_front();
            if (wacc) q.push_back(d);
            if (q.size() == 8) full_seen++;
            checks++;
            if ({cnt8, full8, empty8, af8, ae8} !==
                {4'(q.size()), q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 2}) begin
               failures++;
               $display("FAIL rand_flags ph%0d c%0d got=%0d/%b%b%b%b exp=%0d", ph, c,
                        cnt8, full8, empty8, af8, ae8, q.size());
            end
            checks++;
            if ({rv8, d8_out} !== {racc, last}) begin
               failures++;
               $display("FAIL rand_data ph%0d c%0d got=%b/%h exp=%b/%h", ph, c, rv8, d8_out, racc, last);
            end
         end
      end
      checks++;
      if (full_seen == 0) begin
         failures++;
         $display("FAIL rand_cov got=%0d exp=>0 full cycles", full_seen);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) cyc8(1'b1, 8'(8'h30 + i), 1'b0);
      checks++;
      if (cnt8 !== 4'(3 + 0) + 4'(0) && 1'b1) begin end
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({full8, empty8, af8, ae8, cnt8, rv8, d8_out} !== {4'b0101, 4'd0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL async_rst_u8 got=%b exp=%b", {full8, empty8, af8, ae8, cnt8, rv8, d8_out},
                  {4'b0101, 4'd0, 1'b0, 8'h00});
      end
      checks++;
      if (d4_out !== 8'h00) begin
         failures++;
         $display("FAIL async_rst_dout4 got=%h exp=00", d4_out);
      end
`ifdef STREAM_FIFO_ERR_FLAGS_EN
      checks++;
      if ({ov4, un4} !== 2'b00) begin
         failures++;
         $display("FAIL err_flags_clear got=%b exp=00", {ov4, un4});
      end
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      cyc8(1'b1, 8'h77, 1'b0);
      checks++;
      if ({cnt8, empty8} !== {4'd1, 1'b0}) begin
         failures++;
         $display("FAIL post_rst_write got=%0d/%b exp=1/0", cnt8, empty8);
      end
      cyc8(1'b0, 8'h00, 1'b1);
      checks++;
      if ({rv8, d8_out, empty8} !== {1'b1, 8'h77, 1'b1}) begin
         failures++;
         $display("FAIL post_rst_read got=%b/%h/%b exp=1/77/1", rv8, d8_out, empty8);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_fwft();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
